// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: decides when the IR transmitter sends a packet and which command it
// carries. Packets are sent on a fixed period, and immediately when the bus command changes.
// A watchdog forces a no-motion command when the bus stops writing.
module ir_packet_scheduler #(
    parameter int unsigned PERIOD_CYC      = 10000000,
    parameter int unsigned SEND_WINDOW_CYC = 1400000,
    parameter int unsigned GUARD_CYC       = 50000,
    parameter int unsigned STALE_PACKETS   = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        BUS_CMD_WE,
    input  logic [3:0]  BUS_CMD,
    input  logic        MANUAL_EN,
    input  logic [3:0]  MANUAL_CMD,
    output logic [3:0]  COMMAND,
    output logic        SEND_PACKET,
    output logic        BUSY,
    output logic        CMD_STALE,
    output logic [15:0] PACKET_COUNT
);

    // A period shorter than one full packet would starve or overlap packets.
    if (PERIOD_CYC <= SEND_WINDOW_CYC + GUARD_CYC + 2) begin : g_bad_period
        $error("ir_packet_scheduler: PERIOD_CYC must exceed SEND_WINDOW_CYC + GUARD_CYC + 2");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StSend, StGuard} state_e;

    state_e      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] timer_q;
    logic [31:0] stale_q;
    logic        pending_q;
    logic [3:0]  bus_cmd_q;
    logic [3:0]  cmd_q;
    logic [15:0] packet_count_q;
    logic        send_q;
    logic        busy_q;

    logic        tick;
    logic        urgent;
    logic        go;
    logic        enter_send;
    logic [3:0]  sel;

    assign tick       = (timer_q == PERIOD_CYC - 1);
    assign CMD_STALE  = (stale_q == STALE_PACKETS);
    assign sel        = MANUAL_EN ? MANUAL_CMD : (CMD_STALE ? 4'b0000 : bus_cmd_q);
    // Only a changed bus value on the active source warrants an immediate resend.
    assign urgent     = BUS_CMD_WE && (BUS_CMD != bus_cmd_q) && !MANUAL_EN;
    assign go         = (state_q == StIdle) && pending_q && ENABLE;
    assign enter_send = (state_q == StSetup);

    assign COMMAND      = cmd_q;
    assign SEND_PACKET  = send_q;
    assign BUSY         = busy_q;
    assign PACKET_COUNT = packet_count_q;

    // Next-state logic: SETUP is one cycle, SEND and GUARD run for fixed cycle counts.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            StIdle: begin
                if (go) state_d = StSetup;
            end
            StSetup: begin
                state_d = StSend;
                phase_d = '0;
            end
            StSend: begin
                if (phase_q == SEND_WINDOW_CYC - 1) begin
                    state_d = StGuard;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            StGuard: begin
                if (phase_q == GUARD_CYC - 1) begin
                    state_d = StIdle;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    // State register; envelope and busy are registered from the next state so they are glitch-free.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            phase_q <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            send_q  <= (state_d == StSend);
            busy_q  <= (state_d != StIdle);
        end
    end

    // Free-running period timer, parked at zero while disabled.
    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Single-bit request flag; a new request on the launch edge is kept for the next packet.
    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            pending_q <= 1'b0;
        end else if (tick || urgent) begin
            pending_q <= 1'b1;
        end else if (go) begin
            pending_q <= 1'b0;
        end
    end

    // Bus command register and watchdog; a write beats a simultaneous packet start.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus_cmd_q <= '0;
            stale_q   <= '0;
        end else if (BUS_CMD_WE) begin
            bus_cmd_q <= BUS_CMD;
            stale_q   <= '0;
        end else if (enter_send && (stale_q != STALE_PACKETS)) begin
            stale_q   <= stale_q + 32'd1;
        end
    end

    // Command is captured on launch so it is stable for a full cycle before the envelope rises.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q <= '0;
        end else if (go) begin
            cmd_q <= sel;
        end
    end

    // Packet counter, bumped as each packet enters SEND.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            packet_count_q <= '0;
        end else if (enter_send) begin
            packet_count_q <= packet_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Bench for ir_packet_scheduler: directed vector table, hand-written corner sequences, and a
// random phase, all checked every cycle against a packet-timeline reference model.
module tb_ir_packet_scheduler;

    localparam int unsigned P  = 100;
    localparam int unsigned SW = 20;
    localparam int unsigned GD = 5;
    localparam int unsigned ST = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        BUS_CMD_WE = 1'b0;
    logic [3:0]  BUS_CMD = 4'd0;
    logic        MANUAL_EN = 1'b0;
    logic [3:0]  MANUAL_CMD = 4'd0;
    logic [3:0]  COMMAND;
    logic        SEND_PACKET;
    logic        BUSY;
    logic        CMD_STALE;
    logic [15:0] PACKET_COUNT;

    int total = 0;
    int bad   = 0;

    ir_packet_scheduler #(
        .PERIOD_CYC      (P),
        .SEND_WINDOW_CYC (SW),
        .GUARD_CYC       (GD),
        .STALE_PACKETS   (ST)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .BUS_CMD_WE   (BUS_CMD_WE),
        .BUS_CMD      (BUS_CMD),
        .MANUAL_EN    (MANUAL_EN),
        .MANUAL_CMD   (MANUAL_CMD),
        .COMMAND      (COMMAND),
        .SEND_PACKET  (SEND_PACKET),
        .BUSY         (BUSY),
        .CMD_STALE    (CMD_STALE),
        .PACKET_COUNT (PACKET_COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a packet is a timeline starting at m_start (offset 0 = setup,
    // 1..SW = envelope high, SW+1..SW+GD = guard); everything else is plain bookkeeping.
    int          m_cyc = 0;
    int          m_start = 0;
    int          m_timer = 0;
    int          m_stale = 0;
    bit          m_active = 1'b0;
    bit          m_pend = 1'b0;
    logic [3:0]  m_bus = 4'd0;
    logic [3:0]  m_cmd = 4'd0;
    logic [15:0] m_count = 16'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        int         off;
        logic [3:0] sel;
        bit         go;
        bit         tick;
        bit         urgent;
        if (RESET) begin
            m_cyc = 0; m_start = 0; m_timer = 0; m_stale = 0;
            m_active = 1'b0; m_pend = 1'b0; m_bus = 4'd0; m_cmd = 4'd0; m_count = 16'd0;
            return;
        end
        off    = m_cyc - m_start;
        sel    = MANUAL_EN ? MANUAL_CMD : ((m_stale == ST) ? 4'd0 : m_bus);
        go     = !m_active && m_pend && ENABLE;
        tick   = (m_timer == P - 1);
        urgent = BUS_CMD_WE && (BUS_CMD != m_bus) && !MANUAL_EN;
        if (m_active && off == 0) begin
            m_count = m_count + 16'd1;
            if (m_stale < ST) m_stale++;
        end
        if (BUS_CMD_WE) begin
            m_bus   = BUS_CMD;
            m_stale = 0;
        end
        if (go) begin
            m_cmd    = sel;
            m_active = 1'b1;
            m_start  = m_cyc + 1;
        end else if (m_active && off == SW + GD) begin
            m_active = 1'b0;
        end
        m_timer = ENABLE ? (m_timer + 1) % P : 0;
        if (!ENABLE) m_pend = 1'b0;
        else if (tick || urgent) m_pend = 1'b1;
        else if (go) m_pend = 1'b0;
        m_cyc++;
    endtask

    task automatic model_check();
        int   off;
        logic e_send;
        off    = m_cyc - m_start;
        e_send = m_active && off >= 1 && off <= SW;
        total++;
        if ({COMMAND, SEND_PACKET, BUSY, CMD_STALE, PACKET_COUNT} !==
            {m_cmd, e_send, m_active, (m_stale == ST), m_count}) begin
            bad++;
            $display("FAIL model t=%0t: got cmd=%b send=%b busy=%b stale=%b cnt=%0h, expected cmd=%b send=%b busy=%b stale=%b cnt=%0h",
                     $time, COMMAND, SEND_PACKET, BUSY, CMD_STALE, PACKET_COUNT,
                     m_cmd, e_send, m_active, (m_stale == ST), m_count);
        end
    endtask

    // One clock: model advances with the DUT edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        model_check();
    endtask

    // Skip any envelope in progress, then wait for the next rising edge of SEND_PACKET.
    task automatic wait_rise(input int budget, input string name);
        int n = 0;
        while (SEND_PACKET === 1'b1 && n < budget) begin cycle(); n++; end
        while (SEND_PACKET !== 1'b1 && n < budget) begin cycle(); n++; end
        check(name, {31'd0, SEND_PACKET}, 32'd1);
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        we;
        logic [3:0]  bcmd;
        int          n;
        logic        send;
        logic        busy;
        logic [3:0]  cmd;
        logic [15:0] cnt;
        logic        stale;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n;
        int busy_n;
        int cnt0;

        // Reset, urgent first packet, then the first periodic packet.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0,  2, 1'b0, 1'b0, 4'h0, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 4'h8,  1, 1'b0, 1'b0, 4'h0, 16'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'h8,  1, 1'b0, 1'b1, 4'h8, 16'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'h8, 20, 1'b1, 1'b1, 4'h8, 16'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'h8,  5, 1'b0, 1'b1, 4'h8, 16'd1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'h8, 73, 1'b0, 1'b0, 4'h8, 16'd1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 4'h8,  1, 1'b0, 1'b1, 4'h8, 16'd1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4'h8, 20, 1'b1, 1'b1, 4'h8, 16'd2, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 4'h8,  5, 1'b0, 1'b1, 4'h8, 16'd2, 1'b0};

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                RESET = tbl[i].rst; ENABLE = tbl[i].en; BUS_CMD_WE = tbl[i].we;
                BUS_CMD = tbl[i].bcmd; MANUAL_EN = 1'b0; MANUAL_CMD = 4'h0;
                cycle();
                check($sformatf("tbl%0d.%0d", i, k),
                      {8'd0, SEND_PACKET, BUSY, COMMAND, PACKET_COUNT, CMD_STALE},
                      {8'd0, tbl[i].send, tbl[i].busy, tbl[i].cmd, tbl[i].cnt, tbl[i].stale});
            end
        end

        // Write mid-envelope: current packet keeps its command, the next follows the guard.
        wait_rise(200, "t2 rise");
        repeat (9) cycle();
        BUS_CMD_WE = 1'b1; BUS_CMD = 4'b0001;
        cycle();
        BUS_CMD_WE = 1'b0;
        check("t2 cmd held", COMMAND, 4'b1000);
        n = 0;
        while (SEND_PACKET === 1'b1 && n < 100) begin cycle(); n++; end
        check("t2 cmd in guard", COMMAND, 4'b1000);
        n = 0;
        while (SEND_PACKET !== 1'b1 && n < 50) begin cycle(); n++; end
        check("t2 gap", n, 7);
        check("t2 cmd new", COMMAND, 4'b0001);

        // Watchdog: two more packets without writes saturate it; the next carries 0000.
        wait_rise(200, "t3 rise a");
        wait_rise(200, "t3 rise b");
        check("t3 stale set", {31'd0, CMD_STALE}, 32'd1);
        wait_rise(200, "t3 rise c");
        check("t3 cmd zero", COMMAND, 4'b0000);
        repeat (SW + GD + 2) cycle();
        BUS_CMD_WE = 1'b1; BUS_CMD = 4'b0010;
        cycle();
        BUS_CMD_WE = 1'b0;
        check("t3 stale clr", {31'd0, CMD_STALE}, 32'd0);
        cycle();
        check("t3 setup", {27'd0, SEND_PACKET, COMMAND}, {27'd0, 1'b0, 4'b0010});
        cycle();
        check("t3 latency", {31'd0, SEND_PACKET}, 32'd1);

        // Manual source: bus writes change nothing visible but still feed the watchdog.
        MANUAL_EN = 1'b1; MANUAL_CMD = 4'b1001;
        cnt0 = int'(PACKET_COUNT);
        for (int k = 0; k < 150; k++) begin
            BUS_CMD_WE = (k % 10 == 5);
            BUS_CMD = ((k / 10) % 2 == 1) ? 4'b1000 : 4'b0100;
            cycle();
        end
        BUS_CMD_WE = 1'b0;
        check("t4 manual cmd", COMMAND, 4'b1001);
        check("t4 no urgent", PACKET_COUNT, (cnt0 + 1) & 16'hFFFF);
        MANUAL_EN = 1'b0;
        wait_rise(200, "t4 rise");
        check("t4 stale cleared", {27'd0, CMD_STALE, COMMAND}, {27'd0, 1'b0, 4'b0100});

        // Disable 5 cycles into the envelope: packet completes, then silence.
        repeat (4) cycle();
        ENABLE = 1'b0;
        n = 5;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (SEND_PACKET !== 1'b1) break;
            n++;
        end
        check("t5 window len", n, SW);
        repeat (5) cycle();
        cnt0 = int'(PACKET_COUNT);
        BUS_CMD_WE = 1'b1; BUS_CMD = 4'b0110;
        cycle();
        BUS_CMD_WE = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 150; k++) begin
            cycle();
            if (BUSY !== 1'b0) busy_n++;
        end
        check("t5 idle when off", busy_n, 0);
        check("t5 count frozen", PACKET_COUNT, cnt0);

        // Reset in the middle of an envelope.
        ENABLE = 1'b1; BUS_CMD_WE = 1'b1; BUS_CMD = 4'b0011;
        cycle();
        BUS_CMD_WE = 1'b0;
        cycle();
        cycle();
        check("t5 send before reset", {31'd0, SEND_PACKET}, 32'd1);
        repeat (2) cycle();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("t5 reset mid-packet", {8'd0, SEND_PACKET, BUSY, CMD_STALE, COMMAND, PACKET_COUNT},
              32'd0);

        // Counter wrap from 0xFFFF.
        ENABLE = 1'b0;
        cycle();
        #1;
        force dut.packet_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle();
        release dut.packet_count_q;
        ENABLE = 1'b1; BUS_CMD_WE = 1'b1; BUS_CMD = 4'b0101;
        cycle();
        BUS_CMD_WE = 1'b0;
        cycle();
        cycle();
        check("t6 wrap", {15'd0, SEND_PACKET, PACKET_COUNT}, {15'd0, 1'b1, 16'h0000});

        // Tick and urgent write on the same edge make a single packet.
        repeat (SW + GD + 1) cycle();
        ENABLE = 1'b0;
        cycle();
        ENABLE = 1'b1;
        cnt0 = int'(PACKET_COUNT);
        repeat (P - 1) cycle();
        BUS_CMD_WE = 1'b1; BUS_CMD = 4'b1010;
        cycle();
        BUS_CMD_WE = 1'b0;
        repeat (60) cycle();
        check("t6 one packet", PACKET_COUNT, (cnt0 + 1) & 16'hFFFF);
        check("t6 cmd", COMMAND, 4'b1010);

        // Random phase with varying write density so the watchdog gets exercised.
        for (int s = 0; s < 8; s++) begin
            int rate;
            rate = (s % 3 == 0) ? 4 : ((s % 3 == 1) ? 40 : 400);
            for (int k = 0; k < 500; k++) begin
                RESET      = ($urandom_range(0, 999) == 0);
                if ($urandom_range(0, 199) == 0) ENABLE = !ENABLE;
                if ($urandom_range(0, 149) == 0) MANUAL_EN = !MANUAL_EN;
                BUS_CMD_WE = ($urandom_range(0, rate - 1) == 0);
                BUS_CMD    = 4'($urandom_range(0, 15));
                MANUAL_CMD = 4'($urandom_range(0, 15));
                cycle();
            end
        end
        RESET = 1'b0;
        BUS_CMD_WE = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_packet_scheduler.md
Name: ir_packet_scheduler

Overview:
Controller that sequences the IR transmitter state machine, which latches COMMAND on the SEND_PACKET rising edge and emits bursts while SEND_PACKET is held high. It arbitrates between a bus-written command register and a manual switch source, and emits packets periodically (default 10 Hz). It also emits an immediate packet when the bus command changes. A watchdog forces the command to 0 (no motion) if the bus goes silent.

Parameters:
PERIOD_CYC, 10000000, CLK cycles between scheduled packets (10 Hz at 100 MHz).
SEND_WINDOW_CYC, 1400000, cycles SEND_PACKET is held high. Covers one full blue-car packet of 476 pulses at ~36 kHz, about 1.32M cycles.
GUARD_CYC, 50000, minimum low time on SEND_PACKET between packets.
STALE_PACKETS, 20, packets sent without a bus write before the bus command is considered stale.
Constraint: PERIOD_CYC > SEND_WINDOW_CYC + GUARD_CYC + 2. This is checked by an elaboration-time assertion.

Ports:
CLK  in  1  system clock, 100 MHz
RESET  in  1  synchronous, active-high
ENABLE  in  1  scheduler enable
BUS_CMD_WE  in  1  one-cycle write strobe for the bus command register
BUS_CMD  in  4  {fwd, back, left, right} command from the bus
MANUAL_EN  in  1  selects the manual source over the bus source
MANUAL_CMD  in  4  switch command
COMMAND  out  4  command to the transmitter
SEND_PACKET  out  1  packet envelope to the transmitter
BUSY  out  1  high in any state other than IDLE
CMD_STALE  out  1  bus watchdog expired
PACKET_COUNT  out  16  packets started, wraps

Behaviour:
- Reset values: COMMAND=0, SEND_PACKET=0, BUSY=0, CMD_STALE=0, PACKET_COUNT=0, bus_cmd_q=0, period timer=0, pending=0, stale_cnt=0, state IDLE.
- Reset mid-packet: SEND_PACKET drops to 0 at the first edge with RESET high. No completion is attempted.
- Bus register: BUS_CMD_WE loads bus_cmd_q<=BUS_CMD and clears stale_cnt to 0.
- Watchdog:
  - stale_cnt increments at each SEND entry and saturates at STALE_PACKETS.
  - CMD_STALE = (stale_cnt == STALE_PACKETS).
  - If a write and a SEND entry fall in the same cycle, the write wins and stale_cnt becomes 0.
- Selected command: sel = MANUAL_EN ? MANUAL_CMD : (CMD_STALE ? 4'b0000 : bus_cmd_q). It is combinational and sampled only in IDLE->SETUP.
- Period timer:
  - While ENABLE=1, it counts 0..PERIOD_CYC-1 and wraps.
  - tick = 1 when the count is PERIOD_CYC-1.
  - While ENABLE=0, it is held at 0.
- Pending flag (single bit; requests do not queue):
  - Set by tick.
  - Set by BUS_CMD_WE with BUS_CMD != bus_cmd_q while MANUAL_EN=0 (urgent resend).
  - Cleared on the IDLE->SETUP transition.
  - Forced to 0 while ENABLE=0.
  - Simultaneous set sources produce one request.
- FSM:
  - IDLE: if pending & ENABLE, go to SETUP.
  - SETUP (1 cycle): COMMAND<=sel, SEND_PACKET stays 0. This guarantees COMMAND is stable one full cycle before the SEND_PACKET rising edge. Next state SEND.
  - SEND: SEND_PACKET=1 for exactly SEND_WINDOW_CYC cycles. PACKET_COUNT increments (wrapping 0xFFFF->0) in the first SEND cycle. Next state GUARD.
  - GUARD: SEND_PACKET=0 for exactly GUARD_CYC cycles. Next state IDLE.
- COMMAND changes only in SETUP and is held through SEND and GUARD. Writes during a packet affect only the next packet.
- ENABLE falling during SETUP, SEND or GUARD: the current packet completes normally. The scheduler then idles.
- Requests arriving during SETUP, SEND or GUARD set pending and are serviced on return to IDLE. Latency from IDLE with pending=1 to SEND_PACKET rising is 2 cycles.
- MANUAL_EN toggling has no effect on the packet in progress.

Test Plan:
Test parameters for all scenarios: PERIOD_CYC=100, SEND_WINDOW_CYC=20, GUARD_CYC=5, STALE_PACKETS=3.
1. Reset, then ENABLE=1, bus write 4'b1000 -> SETUP loads COMMAND=1000 and SEND_PACKET rises 2 cycles after the write. SEND_PACKET stays high exactly 20 cycles, then low at least 5 cycles. PACKET_COUNT=1. Periodic packets then start every 100 cycles.
2. Write 4'b0001 in the middle of SEND -> COMMAND stays 1000 until the packet ends. The next packet starts right after GUARD with COMMAND=0001, without waiting for the tick.
3. No bus writes after the first -> after 3 packets CMD_STALE=1 and the 4th packet carries COMMAND=0000. A write of 4'b0010 clears CMD_STALE, and the next packet carries 0010.
4. MANUAL_EN=1, MANUAL_CMD=4'b1001, bus writes active -> all packets carry 1001. Bus writes do not trigger urgent packets but do clear stale_cnt.
5. ENABLE dropped 5 cycles into SEND -> SEND_PACKET stays high for the full 20 cycles, then no further packets are sent. RESET asserted in SEND -> SEND_PACKET=0 and PACKET_COUNT=0 after the next edge.
6. Force PACKET_COUNT=0xFFFF, then trigger a packet -> PACKET_COUNT=0x0000. A tick and an urgent write in the same cycle -> exactly one packet.
